// File: rtl/rd84_vector_sequencer_if.sv
// Handshake bundle between the harness and rd84_vector_sequencer.
// Both channels: a transfer happens on a rising clk edge where valid && ready; the
// source holds valid and data stable until that edge, and ready may depend on state only.
`timescale 1ns/1ps
interface rd84_vector_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_z0;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_z0
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_z0
  );
endinterface

// File: rtl/rd84_vector_sequencer.sv
// Drives 8-bit vectors onto rd84f2, waits a settle time, samples z0 and returns the result.
// Optional macro RD84_SELFCHECK_EN adds a parity cross-check (mismatch, err_cnt).
`timescale 1ns/1ps
module rd84_vector_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rd84_vector_sequencer_if.slave bus,
  output logic [7:0]           x,
  input  logic                 dut_z0,
  output logic [CNT_W-1:0]     vec_cnt,
  output logic [CNT_W-1:0]     ones_cnt,
`ifdef RD84_SELFCHECK_EN
  output logic                 mismatch,
  output logic [CNT_W-1:0]     err_cnt,
`endif
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] rst_sync;
  logic       rst_int_n;
  logic [7:0] settle_cnt;
  logic       out_valid_q;
  logic [7:0] out_data_q;
  logic       out_z0_q;

  // Reset asserts immediately but is released two edges later, synchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state       <= IDLE;
      x           <= 8'h00;
      settle_cnt  <= 8'h00;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_z0_q    <= 1'b0;
      vec_cnt     <= '0;
      ones_cnt    <= '0;
`ifdef RD84_SELFCHECK_EN
      mismatch    <= 1'b0;
      err_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x          <= bus.in_data;
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == 8'h00) state <= CAPTURE;
          else                     settle_cnt <= settle_cnt - 8'h01;
        end
        CAPTURE: begin
          out_z0_q    <= dut_z0;
          out_data_q  <= x;
          out_valid_q <= 1'b1;
`ifdef RD84_SELFCHECK_EN
          mismatch    <= (dut_z0 != ^x);
`endif
          state       <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (vec_cnt != '1)              vec_cnt  <= vec_cnt + 1'b1;
            if (out_z0_q && ones_cnt != '1) ones_cnt <= ones_cnt + 1'b1;
`ifdef RD84_SELFCHECK_EN
            if (mismatch && err_cnt != '1)  err_cnt  <= err_cnt + 1'b1;
            mismatch    <= 1'b0;
`endif
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Not ready while the synchronized reset is still held, so no handshake is lost.
  assign bus.in_ready  = (state == IDLE) && rst_int_n;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_z0    = out_z0_q;
  assign dbg_state     = state;

endmodule
